// File: rtl/cl_rx_frame_checker.sv
// Receive-side additive descrambler (x^7+x^4+1) and CRC-32 frame checker.
// Bytes are descrambled combinationally and registered into a one-deep
// output stage. Each frame's FCS is checked against the CRC-32 residue,
// and saturating frame and error counters are maintained.
//
// Handshake: a byte moves on any clk edge where valid && ready is high.
// s_ready = !m_valid || m_ready, so the output register can always take a
// new byte when it is empty or being drained in the same cycle. While
// m_valid && !m_ready, m_data/m_last/m_crc_ok hold and no input is taken.
module cl_rx_frame_checker #(
    parameter logic [6:0] SEED          = 7'h7F,
    parameter bit         DESCRAMBLE_EN = 1'b1,
    parameter int         CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic             m_crc_ok,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    localparam logic [31:0]      CRC_POLY_R  = 32'hEDB8_8320;
    localparam logic [31:0]      CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [6:0]       lfsr_q, lfsr_d;
    logic [31:0]      crc_q, crc_d;
    logic             m_valid_q, m_valid_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_last_q, m_last_d;
    logic             m_crc_ok_q, m_crc_ok_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             accept;
    logic [6:0]       lfsr_src;
    logic [31:0]      crc_src;
    logic [6:0]       lfsr_nxt;
    logic [7:0]       desc_data;
    logic             desc_k;
    logic [31:0]      crc_nxt;
    logic             crc_good;

    assign s_ready = !m_valid_q || m_ready;
    assign accept  = s_valid && s_ready;

    // A new frame always starts from the seed and the all-ones CRC.
    assign lfsr_src = (state_q == IDLE) ? SEED : lfsr_q;
    assign crc_src  = (state_q == IDLE) ? CRC_INIT : crc_q;

    // Descramble one byte, bit 0 first, advancing a copy of the LFSR.
    always_comb begin
        lfsr_nxt  = lfsr_src;
        desc_data = s_data;
        desc_k    = 1'b0;
        if (DESCRAMBLE_EN) begin
            for (int i = 0; i < 8; i++) begin
                desc_k       = lfsr_nxt[6] ^ lfsr_nxt[3];
                lfsr_nxt     = {lfsr_nxt[5:0], desc_k};
                desc_data[i] = s_data[i] ^ desc_k;
            end
        end
    end

    // Reflected CRC-32 update over the descrambled byte, LSB first.
    always_comb begin
        crc_nxt = crc_src ^ {24'd0, desc_data};
        for (int i = 0; i < 8; i++) begin
            crc_nxt = crc_nxt[0] ? ((crc_nxt >> 1) ^ CRC_POLY_R) : (crc_nxt >> 1);
        end
    end

    assign crc_good = (crc_nxt == CRC_RESIDUE);

    // Next-state, output register and counter updates on accepted bytes.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        crc_d       = crc_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        m_crc_ok_d  = m_crc_ok_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (accept) begin
            m_valid_d  = 1'b1;
            m_data_d   = desc_data;
            m_last_d   = s_last;
            m_crc_ok_d = s_last && crc_good;
            if (s_last) begin
                state_d = IDLE;
                lfsr_d  = SEED;
                crc_d   = CRC_INIT;
                if (frame_cnt_q != CNT_MAX) begin
                    frame_cnt_d = frame_cnt_q + CNT_ONE;
                end
                if (!crc_good && (err_cnt_q != CNT_MAX)) begin
                    err_cnt_d = err_cnt_q + CNT_ONE;
                end
            end else begin
                state_d = IN_FRAME;
                lfsr_d  = lfsr_nxt;
                crc_d   = crc_nxt;
            end
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            crc_q       <= CRC_INIT;
            m_valid_q   <= 1'b0;
            m_data_q    <= 8'h00;
            m_last_q    <= 1'b0;
            m_crc_ok_q  <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            crc_q       <= crc_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            m_crc_ok_q  <= m_crc_ok_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign m_crc_ok  = m_crc_ok_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_cl_rx_frame_checker.sv
// Bench for cl_rx_frame_checker: one descrambling instance (16-bit counters)
// and one bypass instance (2-bit counters, to reach saturation) share the
// same input stream and m_ready. A frame-level model predicts every output.
module tb_cl_rx_frame_checker;

    localparam logic [6:0]  SEED_TB = 7'h7F;
    localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;
    localparam int          MAX_S   = 65535;
    localparam int          MAX_B   = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       s_valid = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic       s_last  = 1'b0;
    logic       m_ready = 1'b1;

    logic        s_ready_s, m_valid_s, m_last_s, m_crc_ok_s;
    logic [7:0]  m_data_s;
    logic [15:0] frame_cnt_s, err_cnt_s;
    logic        s_ready_b, m_valid_b, m_last_b, m_crc_ok_b;
    logic [7:0]  m_data_b;
    logic [1:0]  frame_cnt_b, err_cnt_b;

    cl_rx_frame_checker #(.SEED(SEED_TB), .DESCRAMBLE_EN(1'b1), .CNT_W(16)) dut_s (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_s),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid_s), .m_ready(m_ready),
        .m_data(m_data_s), .m_last(m_last_s), .m_crc_ok(m_crc_ok_s),
        .frame_cnt(frame_cnt_s), .err_cnt(err_cnt_s)
    );

    cl_rx_frame_checker #(.SEED(SEED_TB), .DESCRAMBLE_EN(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid_b), .m_ready(m_ready),
        .m_data(m_data_b), .m_last(m_last_b), .m_crc_ok(m_crc_ok_b),
        .frame_cnt(frame_cnt_b), .err_cnt(err_cnt_b)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    bit chk_en       = 1'b0;
    bit rand_ready   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Keystream byte n of a frame: run the x^7+x^4+1 generator from the seed.
    function automatic logic [7:0] keystream_byte(input int n);
        logic [6:0] l;
        logic [7:0] ks;
        logic       k;
        l  = SEED_TB;
        ks = 8'h00;
        for (int b = 0; b < 8 * (n + 1); b++) begin
            k = l[6] ^ l[3];
            l = {l[5:0], k};
            if (b >= 8 * n) ks[b - 8 * n] = k;
        end
        return ks;
    endfunction

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    logic [7:0] mdl_frame [0:255];
    int         mdl_len = 0;
    bit         mdl_valid = 1'b0;
    logic [7:0] mdl_data_s = 8'h00, mdl_data_b = 8'h00;
    bit         mdl_last = 1'b0, mdl_ok_s = 1'b0, mdl_ok_b = 1'b0;
    int         mdl_fcnt_s = 0, mdl_ecnt_s = 0, mdl_fcnt_b = 0, mdl_ecnt_b = 0;

    // Frame-level model: collect the frame; at its end compute the CRC of
    // the whole descrambled frame and compare with the residue.
    always @(posedge clk) begin
        logic [31:0] c_s, c_b;
        if (rst) begin
            mdl_len = 0; mdl_valid = 1'b0; mdl_data_s = 8'h00; mdl_data_b = 8'h00;
            mdl_last = 1'b0; mdl_ok_s = 1'b0; mdl_ok_b = 1'b0;
            mdl_fcnt_s = 0; mdl_ecnt_s = 0; mdl_fcnt_b = 0; mdl_ecnt_b = 0;
        end else if (s_valid && (!mdl_valid || m_ready)) begin
            mdl_frame[mdl_len % 256] = s_data;
            mdl_len++;
            mdl_valid  = 1'b1;
            mdl_data_b = s_data;
            mdl_data_s = s_data ^ keystream_byte(mdl_len - 1);
            mdl_last   = s_last;
            mdl_ok_s   = 1'b0;
            mdl_ok_b   = 1'b0;
            if (s_last) begin
                c_s = 32'hFFFF_FFFF;
                c_b = 32'hFFFF_FFFF;
                for (int i = 0; i < mdl_len; i++) begin
                    c_s = crc_step(c_s, mdl_frame[i % 256] ^ keystream_byte(i));
                    c_b = crc_step(c_b, mdl_frame[i % 256]);
                end
                mdl_ok_s = (c_s == RESIDUE);
                mdl_ok_b = (c_b == RESIDUE);
                if (mdl_fcnt_s < MAX_S) mdl_fcnt_s++;
                if (mdl_fcnt_b < MAX_B) mdl_fcnt_b++;
                if (!mdl_ok_s && mdl_ecnt_s < MAX_S) mdl_ecnt_s++;
                if (!mdl_ok_b && mdl_ecnt_b < MAX_B) mdl_ecnt_b++;
                mdl_len = 0;
            end
        end else if (m_ready) begin
            mdl_valid = 1'b0;
        end
    end

    // ---------------- scoreboard: per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("s_ready_s", 32'(s_ready_s), 32'(!mdl_valid || m_ready));
            check("s_ready_b", 32'(s_ready_b), 32'(!mdl_valid || m_ready));
            check("m_valid_s", 32'(m_valid_s), 32'(mdl_valid));
            check("m_valid_b", 32'(m_valid_b), 32'(mdl_valid));
            if (mdl_valid) begin
                check("m_data_s", 32'(m_data_s), 32'(mdl_data_s));
                check("m_data_b", 32'(m_data_b), 32'(mdl_data_b));
                check("m_last_s", 32'(m_last_s), 32'(mdl_last));
                check("m_last_b", 32'(m_last_b), 32'(mdl_last));
                check("m_crc_ok_s", 32'(m_crc_ok_s), 32'(mdl_ok_s));
                check("m_crc_ok_b", 32'(m_crc_ok_b), 32'(mdl_ok_b));
            end
            check("frame_cnt_s", 32'(frame_cnt_s), 32'(mdl_fcnt_s));
            check("err_cnt_s", 32'(err_cnt_s), 32'(mdl_ecnt_s));
            check("frame_cnt_b", 32'(frame_cnt_b), 32'(mdl_fcnt_b));
            check("err_cnt_b", 32'(err_cnt_b), 32'(mdl_ecnt_b));
        end
    end

    // Output capture {crc_ok, last, data} for literal end-of-test checks.
    logic [9:0] cap_s[$];
    logic [9:0] cap_b[$];
    always @(negedge clk) begin
        if (chk_en && m_valid_s && m_ready) cap_s.push_back({m_crc_ok_s, m_last_s, m_data_s});
        if (chk_en && m_valid_b && m_ready) cap_b.push_back({m_crc_ok_b, m_last_b, m_data_b});
    end

    function automatic logic [9:0] cs_at(input int i);
        return (i < cap_s.size()) ? cap_s[i] : 10'h3FF;
    endfunction
    function automatic logic [9:0] cb_at(input int i);
        return (i < cap_b.size()) ? cap_b[i] : 10'h3FF;
    endfunction

    // Random back-pressure, changed just after each rising edge.
    always @(posedge clk) begin
        #2;
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- driver tasks (called at posedge+2) ----------------
    task automatic send_byte(input logic [7:0] d, input logic l);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_ready_s;
            @(posedge clk);
            #2;
            n++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        cap_s.delete();
        cap_b.delete();
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        repeat (4) @(posedge clk);
        #2;
    endtask

    logic [7:0] good [0:12];
    logic [7:0] sc   [0:12];

    task automatic send_frame(input bit scrambled);
        for (int i = 0; i < 13; i++) send_byte(scrambled ? sc[i] : good[i], i == 12);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] c;
        good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h26, 8'h39, 8'hF4, 8'hCB};
        for (int i = 0; i < 13; i++) sc[i] = good[i] ^ keystream_byte(i);

        // Pin the model against known values.
        check("pin_ks0", 32'(keystream_byte(0)), 32'h70);
        check("pin_ks1", 32'(keystream_byte(1)), 32'h4F);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) c = crc_step(c, good[i]);
        check("pin_crc_check", ~c, 32'hCBF4_3926);

        @(posedge clk);
        #2;
        chk_en = 1'b1;
        do_reset();
        check("reset_m_valid", 32'(m_valid_s), 32'd0);
        check("reset_m_data", 32'(m_data_s), 32'd0);
        check("reset_s_ready", 32'(s_ready_s), 32'd1);
        check("reset_frame_cnt", 32'(frame_cnt_s), 32'd0);

        // Two keystream bytes descramble to zero; one-cycle latency.
        send_byte(8'h70, 1'b0);
        check("t1_latency", 32'(m_valid_s), 32'd1);
        send_byte(8'h4F, 1'b1);
        drain();
        check("t1_count", 32'(cap_s.size()), 32'd2);
        check("t1_byte0", 32'(cs_at(0)), 32'h000);
        check("t1_byte1", 32'(cs_at(1)), 32'h100);

        // Bypass instance: known-good plain frame.
        do_reset();
        send_frame(1'b0);
        drain();
        check("t2_count", 32'(cap_b.size()), 32'd13);
        for (int i = 0; i < 13; i++) check("t2_data", 32'(cb_at(i)), {22'd0, i == 12, i == 12, good[i]});
        check("t2_frame_cnt", 32'(frame_cnt_b), 32'd1);
        check("t2_err_cnt", 32'(err_cnt_b), 32'd0);

        // Same frame with a corrupted final FCS byte.
        do_reset();
        for (int i = 0; i < 13; i++) send_byte((i == 12) ? 8'hCA : good[i], i == 12);
        drain();
        check("t3_last", 32'(cb_at(12)), 32'h1CA);
        check("t3_frame_cnt", 32'(frame_cnt_b), 32'd1);
        check("t3_err_cnt", 32'(err_cnt_b), 32'd1);

        // Scrambled good frame twice, back to back.
        do_reset();
        send_frame(1'b1);
        send_frame(1'b1);
        drain();
        check("t4_count", 32'(cap_s.size()), 32'd26);
        for (int i = 0; i < 26; i++)
            check("t4_data", 32'(cs_at(i)), {22'd0, (i % 13) == 12, (i % 13) == 12, good[i % 13]});
        check("t4_frame_cnt", 32'(frame_cnt_s), 32'd2);
        check("t4_err_cnt", 32'(err_cnt_s), 32'd0);

        // Random back-pressure: same bytes, none dropped or duplicated.
        do_reset();
        rand_ready = 1'b1;
        send_frame(1'b1);
        drain();
        check("t5_count", 32'(cap_s.size()), 32'd13);
        for (int i = 0; i < 13; i++) check("t5_data", 32'(cs_at(i)), {22'd0, i == 12, i == 12, good[i]});
        check("t5_frame_cnt", 32'(frame_cnt_s), 32'd1);

        // Reset after byte 5 of a frame, then a full good frame.
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(sc[i], 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_m_valid", 32'(m_valid_s), 32'd0);
        check("t6_rst_frame_cnt", 32'(frame_cnt_s), 32'd0);
        check("t6_rst_err_cnt", 32'(err_cnt_s), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        cap_s.delete();
        cap_b.delete();
        send_frame(1'b1);
        drain();
        check("t6_count", 32'(cap_s.size()), 32'd13);
        check("t6_last", 32'(cs_at(12)), {22'd0, 2'b11, good[12]});
        check("t6_frame_cnt", 32'(frame_cnt_s), 32'd1);
        check("t6_err_cnt", 32'(err_cnt_s), 32'd0);

        // Five 1-byte frames: 2-bit counters saturate at 3.
        do_reset();
        repeat (5) send_byte(8'h00, 1'b1);
        drain();
        check("t7_frame_cnt_b", 32'(frame_cnt_b), 32'd3);
        check("t7_err_cnt_b", 32'(err_cnt_b), 32'd3);
        check("t7_frame_cnt_s", 32'(frame_cnt_s), 32'd5);
        check("t7_err_cnt_s", 32'(err_cnt_s), 32'd5);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #400000;
        tests_run++;
        tests_failed++;
        $display("FAIL global_timeout: got running, expected finished at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
